// File: rtl/ysyx_23060096_rf_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_rf_pkg
//   Definitions shared by the multi-port register file and its scoreboard:
//   - rf_nreg()    : register count for a given index width
//   - ZERO_REG     : index of the hardwired-zero register
//   - sb_op_e      : per-register scoreboard update action
//   - RF_SLICE     : picks element `idx` of width `w` out of a flat port bus
// ---------------------------------------------------------------------------
`ifndef YSYX_23060096_RF_SLICE
`define YSYX_23060096_RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package ysyx_23060096_rf_pkg;

    // Index of the register that always reads as zero.
    localparam int ZERO_REG = 0;

    // Scoreboard action for one register in one cycle.
    typedef enum logic [1:0] {
        SB_HOLD  = 2'd0,
        SB_CLEAR = 2'd1,
        SB_SET   = 2'd2
    } sb_op_e;

    // Number of architectural registers addressed by an index of addr_width bits.
    function automatic int rf_nreg(input int addr_width);
        return int'(32'd1 << addr_width);
    endfunction

endpackage

// File: rtl/ysyx_23060096_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_rf_scoreboard
//   Per-register busy tracking for the register file. A register becomes busy
//   when an instruction writing it is issued and becomes free again when any
//   write port writes it back. A flush clears every busy bit.
//   Priority per register (r != 0): flush > issue > writeback > hold.
//   Register 0 is never busy.
//
//   Ports
//     clk, rstn   clock, async active-low reset
//     raddr       flat read indices (NR_RD x ADDR_WIDTH)
//     w_en/waddr  write strobes and flat write indices (NR_WR ports)
//     iss_en      issue strobe, iss_rd is the destination being issued
//     flush       clear all busy bits
//     busy_vec    registered busy state, bit 0 always 0
//     rrdy        per read port: operand valid (not busy, or bypassed)
// ---------------------------------------------------------------------------
module ysyx_23060096_rf_scoreboard
    import ysyx_23060096_rf_pkg::*;
#(
    parameter  int ADDR_WIDTH = 5,
    parameter  int NR_RD      = 2,
    parameter  int NR_WR      = 2,
    parameter  int BYPASS     = 1,
    localparam int NREG       = rf_nreg(ADDR_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
    input  logic [NR_WR-1:0]            w_en,
    input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
    input  logic                        iss_en,
    input  logic [ADDR_WIDTH-1:0]       iss_rd,
    input  logic                        flush,
    output logic [NREG-1:0]             busy_vec,
    output logic [NR_RD-1:0]            rrdy
);

    logic [NREG-1:0]       busy_r;
    logic [NREG-1:0]       busy_nxt_s;
    logic [NREG-1:0]       wr_hit_s;
    logic [ADDR_WIDTH-1:0] rd_idx_s;
    sb_op_e                op_s;

    // One-hot-or of all register indices written back this cycle.
    always_comb begin
        wr_hit_s = '0;
        for (int j = 0; j < NR_WR; j++) begin
            wr_hit_s[`YSYX_23060096_RF_SLICE(waddr, j, ADDR_WIDTH)] =
                wr_hit_s[`YSYX_23060096_RF_SLICE(waddr, j, ADDR_WIDTH)] | w_en[j];
        end
    end

    // Next busy state: choose an action per register, then apply it.
    always_comb begin
        busy_nxt_s = busy_r;
        op_s       = SB_HOLD;
        for (int r = 0; r < NREG; r++) begin
            if (r == ZERO_REG) begin
                op_s = SB_CLEAR;
            end else if (flush) begin
                op_s = SB_CLEAR;
            end else if (iss_en && (iss_rd == ADDR_WIDTH'(r))) begin
                // A newer producer was issued; its result is still pending
                // even if an older one writes back in the same cycle.
                op_s = SB_SET;
            end else if (wr_hit_s[r]) begin
                op_s = SB_CLEAR;
            end else begin
                op_s = SB_HOLD;
            end

            case (op_s)
                SB_SET:   busy_nxt_s[r] = 1'b1;
                SB_CLEAR: busy_nxt_s[r] = 1'b0;
                SB_HOLD:  busy_nxt_s[r] = busy_r[r];
                default:  busy_nxt_s[r] = busy_r[r];
            endcase
        end
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy_vec = busy_r;

    // Operand-ready per read port; a same-cycle write counts only with bypass.
    always_comb begin
        rrdy     = '0;
        rd_idx_s = '0;
        for (int i = 0; i < NR_RD; i++) begin
            rd_idx_s = `YSYX_23060096_RF_SLICE(raddr, i, ADDR_WIDTH);
            if (rd_idx_s == ADDR_WIDTH'(ZERO_REG)) begin
                rrdy[i] = 1'b1;
            end else if (!busy_r[rd_idx_s]) begin
                rrdy[i] = 1'b1;
            end else if ((BYPASS != 0) && wr_hit_s[rd_idx_s]) begin
                rrdy[i] = 1'b1;
            end else begin
                rrdy[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ysyx_23060096_regfile_mp.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_regfile_mp
//   Multi-port integer register file with hardwired-zero x0, optional
//   write-to-read bypass and a busy scoreboard (see rf_scoreboard).
//
//   Ports
//     clk, rstn   core clock, async active-low reset
//     raddr       NR_RD read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//     rdata       NR_RD combinational read data
//     rrdy        NR_RD operand-valid flags
//     w_en        NR_WR write strobes
//     waddr/wdata NR_WR write indices / write data
//     iss_en      issue strobe, marks iss_rd busy
//     iss_rd      destination register being issued
//     flush       clears all busy bits
//     busy_vec    scoreboard state, bit 0 always 0
//
//   When several write ports target one register in the same cycle the
//   highest-numbered port wins, both for storage and for the bypass.
// ---------------------------------------------------------------------------
module ysyx_23060096_regfile_mp
    import ysyx_23060096_rf_pkg::*;
#(
    parameter  int ADDR_WIDTH = 5,
    parameter  int DATA_WIDTH = 32,
    parameter  int NR_RD      = 2,
    parameter  int NR_WR      = 2,
    parameter  int BYPASS     = 1,
    localparam int NREG       = rf_nreg(ADDR_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NR_RD*DATA_WIDTH-1:0] rdata,
    output logic [NR_RD-1:0]            rrdy,
    input  logic [NR_WR-1:0]            w_en,
    input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NR_WR*DATA_WIDTH-1:0] wdata,
    input  logic                        iss_en,
    input  logic [ADDR_WIDTH-1:0]       iss_rd,
    input  logic                        flush,
    output logic [NREG-1:0]             busy_vec
);

    logic [DATA_WIDTH-1:0] rf_r [NREG];
    logic [ADDR_WIDTH-1:0] rd_idx_s;
    logic [ADDR_WIDTH-1:0] wr_idx_s;
    logic [DATA_WIDTH-1:0] rd_val_s;

    // Storage: ports are applied in ascending order so the last (highest)
    // port's assignment to a shared index is the one that takes effect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                rf_r[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NR_WR; j++) begin
                if (w_en[j] &&
                    (`YSYX_23060096_RF_SLICE(waddr, j, ADDR_WIDTH) != ADDR_WIDTH'(ZERO_REG))) begin
                    rf_r[`YSYX_23060096_RF_SLICE(waddr, j, ADDR_WIDTH)] <=
                        `YSYX_23060096_RF_SLICE(wdata, j, DATA_WIDTH);
                end
            end
        end
    end

    // Read mux with optional bypass; forced to zero while reset is asserted
    // so a write presented during reset is never forwarded.
    always_comb begin
        rdata    = '0;
        rd_idx_s = '0;
        wr_idx_s = '0;
        rd_val_s = '0;
        for (int i = 0; i < NR_RD; i++) begin
            rd_idx_s = `YSYX_23060096_RF_SLICE(raddr, i, ADDR_WIDTH);
            rd_val_s = rf_r[rd_idx_s];
            for (int j = 0; j < NR_WR; j++) begin
                wr_idx_s = `YSYX_23060096_RF_SLICE(waddr, j, ADDR_WIDTH);
                if ((BYPASS != 0) && w_en[j] && (wr_idx_s == rd_idx_s) &&
                    (rd_idx_s != ADDR_WIDTH'(ZERO_REG))) begin
                    rd_val_s = `YSYX_23060096_RF_SLICE(wdata, j, DATA_WIDTH);
                end else begin
                    rd_val_s = rd_val_s;
                end
            end
            if (!rstn) begin
                `YSYX_23060096_RF_SLICE(rdata, i, DATA_WIDTH) = '0;
            end else begin
                `YSYX_23060096_RF_SLICE(rdata, i, DATA_WIDTH) = rd_val_s;
            end
        end
    end

    ysyx_23060096_rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NR_RD      (NR_RD),
        .NR_WR      (NR_WR),
        .BYPASS     (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rstn     (rstn),
        .raddr    (raddr),
        .w_en     (w_en),
        .waddr    (waddr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .busy_vec (busy_vec),
        .rrdy     (rrdy)
    );

endmodule
